// File: rtl/uart_tx_bus_master_if.sv
// Byte stream plus register-bus signals between the UART print master and its
// neighbours. The master modport is the print engine; the slave modport is the
// side that supplies bytes and answers register reads.
interface uart_tx_bus_master_if #(
    parameter int BusDataWidth  = 32,
    parameter int UartDataWidth = 8
);
    logic                     byte_valid_i;
    logic [UartDataWidth-1:0] byte_data_i;
    logic                     byte_ready_o;
    logic                     bus_wr_en_o;
    logic [BusDataWidth-1:0]  bus_addr_o;
    logic [BusDataWidth-1:0]  bus_wdata_o;
    logic [BusDataWidth-1:0]  bus_rdata_i;

    modport master (
        input  byte_valid_i, byte_data_i, bus_rdata_i,
        output byte_ready_o, bus_wr_en_o, bus_addr_o, bus_wdata_o
    );

    modport slave (
        output byte_valid_i, byte_data_i, bus_rdata_i,
        input  byte_ready_o, bus_wr_en_o, bus_addr_o, bus_wdata_o
    );
endinterface

// File: rtl/uart_tx_bus_master.sv
// Host-side register master for the UART controller: programs the baud select
// once after reset, then for every streamed byte polls tx_busy and writes the
// byte into the tx data register.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_INIT  | one-cycle write of BaudSel to the baud register
// ST_IDLE  | ready for a byte; status address parked on the bus
// ST_POLL  | reading status until tx_busy clears or the poll budget runs out
// ST_WRITE | one-cycle write of the latched byte to the tx data register
// ST_GAP   | lets the controller's registered tx_busy rise before next poll
module uart_tx_bus_master #(
    parameter int                      BusDataWidth  = 32,
    parameter int                      UartDataWidth = 8,
    parameter logic [BusDataWidth-1:0] BaseAddr      = '0,
    parameter logic [1:0]              BaudSel       = 2'd0,
    parameter int                      GapCycles     = 4,
    parameter int                      PollTimeout   = 65535,
    parameter int                      CountWidth    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    uart_tx_bus_master_if.master   bus,
    output logic                   busy_o,
    output logic                   timeout_o,
    output logic [CountWidth-1:0]  tx_count_o
);

    localparam int PollW = (PollTimeout > 1) ? $clog2(PollTimeout) : 1;
    localparam int GapW  = (GapCycles > 1) ? $clog2(GapCycles) : 1;
    localparam logic [PollW-1:0] PollLoad = PollW'(PollTimeout - 1);
    localparam logic [GapW-1:0]  GapLoad  = GapW'(GapCycles - 1);

    localparam logic [BusDataWidth-1:0] AddrBaud   = BaseAddr;
    localparam logic [BusDataWidth-1:0] AddrStatus = BaseAddr + BusDataWidth'(1);
    localparam logic [BusDataWidth-1:0] AddrTxData = BaseAddr + BusDataWidth'(3);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_POLL,
        ST_WRITE,
        ST_GAP
    } state_t;

    state_t                   state, state_nx, state_out;
    logic [UartDataWidth-1:0] byte_q;
    logic [PollW-1:0]         poll_cnt;
    logic [GapW-1:0]          gap_cnt;
    logic [CountWidth-1:0]    tx_count_q;
    logic                     timeout_q;
    logic                     tx_busy;
    logic                     accept;
    logic                     poll_expire;

    assign tx_busy     = bus.bus_rdata_i[2];
    assign accept      = (state == ST_IDLE) && bus.byte_valid_i;
    assign poll_expire = (state == ST_POLL) && tx_busy && (poll_cnt == '0);

    // Reset forces the INIT decode on the outputs even before the state register updates.
    assign state_out = rst_i ? ST_INIT : state;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_INIT;
        else       state <= state_nx;
    end

    // Next-state selection and Moore output decode.
    always_comb begin
        state_nx         = state;
        bus.byte_ready_o = 1'b0;
        bus.bus_wr_en_o  = 1'b0;
        bus.bus_addr_o   = AddrStatus;
        bus.bus_wdata_o  = '0;

        case (state)
            ST_INIT:  state_nx = ST_IDLE;
            ST_IDLE:  if (accept) state_nx = ST_POLL;
            ST_POLL:  begin
                if (!tx_busy)        state_nx = ST_WRITE;
                else if (poll_expire) state_nx = ST_IDLE;
            end
            ST_WRITE: state_nx = ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_nx = ST_IDLE;
            default:  state_nx = ST_INIT;
        endcase

        case (state_out)
            ST_INIT: begin
                bus.bus_wr_en_o      = 1'b1;
                bus.bus_addr_o       = AddrBaud;
                bus.bus_wdata_o[1:0] = BaudSel;
            end
            ST_IDLE:  bus.byte_ready_o = 1'b1;
            ST_WRITE: begin
                bus.bus_wr_en_o                     = 1'b1;
                bus.bus_addr_o                      = AddrTxData;
                bus.bus_wdata_o[UartDataWidth-1:0]  = byte_q;
            end
            default: ;
        endcase
    end

    // Byte latch, down-counting poll/gap timers, sent counter and timeout pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_q     <= '0;
            poll_cnt   <= '0;
            gap_cnt    <= '0;
            tx_count_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= poll_expire;
            if (accept) begin
                byte_q   <= bus.byte_data_i;
                poll_cnt <= PollLoad;
            end else if ((state == ST_POLL) && tx_busy && !poll_expire) begin
                poll_cnt <= poll_cnt - 1'b1;
            end
            if (state == ST_WRITE) begin
                tx_count_q <= tx_count_q + 1'b1;
                gap_cnt    <= GapLoad;
            end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign busy_o     = (state_out != ST_IDLE);
    assign timeout_o  = timeout_q;
    assign tx_count_o = tx_count_q;

endmodule
